rect_solve: RTL and testbench

- Inverse of the area/perimeter operator: accepts a rectangle's area and perimeter and recovers width W and height H, with W <= H.
- Sequential search, one candidate width per clock.
- Sits beside the area/perimeter op in the Mini SPU datapath with a valid/ready handshake on each side.
- Reports whether an integer rectangle with 0..2^WIDTH-1 sides exists.

---
 rtl/rect_solve_if.sv | 27 ++
 rtl/rect_solve.sv | 123 ++++++++++++
 tb/tb_rect_solve.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rect_solve_if.sv
// rect_solve_if: request/response handshake bundle for rect_solve.
//   Request side : in_valid, in_ready, area_i (2*WIDTH), perim_i (WIDTH+2)
//   Response side: out_valid, out_ready, found_o, w_o, h_o (WIDTH each)
// The master modport is the requester/consumer; the slave modport is the solver.
interface rect_solve_if #(
    parameter int unsigned WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   area_i;
    logic [WIDTH+1:0]     perim_i;
    logic                 out_valid;
    logic                 out_ready;
    logic                 found_o;
    logic [WIDTH-1:0]     w_o;
    logic [WIDTH-1:0]     h_o;

    modport master (
        output in_valid, area_i, perim_i, out_ready,
        input  in_ready, out_valid, found_o, w_o, h_o
    );

    modport slave (
        input  in_valid, area_i, perim_i, out_ready,
        output in_ready, out_valid, found_o, w_o, h_o
    );
endinterface

// File: rtl/rect_solve.sv
// rect_solve: recovers rectangle sides W <= H from area and perimeter by a
// sequential search over candidate widths, one candidate per clock.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : rect_solve_if slave modport
//           in_valid/in_ready  + area_i/perim_i      request handshake
//           out_valid/out_ready + found_o/w_o/h_o    result handshake
module rect_solve #(
    parameter int unsigned WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    rect_solve_if.slave  bus
);
    localparam int unsigned SW  = WIDTH + 1;     // half-perimeter / candidate width
    localparam int unsigned AW  = 2 * WIDTH;     // area
    localparam int unsigned PRW = 2 * WIDTH + 2; // product, wide enough for any w*h

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     a_q, a_d;
    logic              odd_q, odd_d;
    logic [SW-1:0]     s_q, s_d;
    logic [SW-1:0]     w_q, w_d;
    logic              found_q, found_d;
    logic [WIDTH-1:0]  wo_q, wo_d;
    logic [WIDTH-1:0]  ho_q, ho_d;

    logic [SW-1:0]     h;
    logic [PRW-1:0]    prod;
    logic              h_fits;
    logic              a_match;
    logic              last_cand;

    // w never exceeds s/2, so s - w cannot underflow.
    assign h         = s_q - w_q;
    assign prod      = {{(PRW-SW){1'b0}}, w_q} * {{(PRW-SW){1'b0}}, h};
    // h fits in WIDTH bits exactly when its top bit is clear.
    assign h_fits    = ~h[WIDTH];
    assign a_match   = (prod == {2'b00, a_q});
    assign last_cand = (w_q == (s_q >> 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            odd_q   <= 1'b0;
            s_q     <= '0;
            w_q     <= '0;
            found_q <= 1'b0;
            wo_q    <= '0;
            ho_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            odd_q   <= odd_d;
            s_q     <= s_d;
            w_q     <= w_d;
            found_q <= found_d;
            wo_q    <= wo_d;
            ho_q    <= ho_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        odd_d   = odd_q;
        s_d     = s_q;
        w_d     = w_q;
        found_d = found_q;
        wo_d    = wo_q;
        ho_d    = ho_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.area_i;
                    odd_d   = bus.perim_i[0];
                    s_d     = bus.perim_i[WIDTH+1:1];
                    w_d     = '0;
                    state_d = StSearch;
                end
            end
            StSearch: begin
                if (odd_q) begin
                    // No integer rectangle has an odd perimeter.
                    found_d = 1'b0;
                    wo_d    = '0;
                    ho_d    = '0;
                    state_d = StDone;
                end else if (h_fits && a_match) begin
                    found_d = 1'b1;
                    wo_d    = w_q[WIDTH-1:0];
                    ho_d    = h[WIDTH-1:0];
                    state_d = StDone;
                end else if (last_cand) begin
                    found_d = 1'b0;
                    wo_d    = '0;
                    ho_d    = '0;
                    state_d = StDone;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.found_o   = found_q;
    assign bus.w_o       = wo_q;
    assign bus.h_o       = ho_q;
endmodule

// File: tb/tb_rect_solve.sv
module tb_rect_solve;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rect_solve_if #(.WIDTH(4)) bus ();

    rect_solve #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] area;
        logic [5:0] perim;
        logic       found;
        logic [3:0] w;
        logic [3:0] h;
        int         lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request; returns capture-to-out_valid latency.
    task automatic send(input logic [7:0] a, input logic [5:0] p, output int lat,
                        output logic busy_bad, output logic timeout);
        @(negedge clk);
        check("in_ready_before_req", 32'(bus.in_ready), 32'd1);
        bus.area_i   = a;
        bus.perim_i  = p;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat      = 0;
        busy_bad = 1'b0;
        timeout  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
        if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
    endtask

    // Complete the result handshake; in_valid held high on that edge must not capture.
    task automatic accept(input logic f, input logic [3:0] w, input logic [3:0] h);
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.area_i    = 8'd99;
        bus.perim_i   = 6'd20;
        @(posedge clk);
        #1;
        check("out_valid_after_ack", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_ack", 32'(bus.in_ready), 32'd1);
        check("found_held_idle", 32'(bus.found_o), 32'(f));
        check("w_held_idle", 32'(bus.w_o), 32'(w));
        check("h_held_idle", 32'(bus.h_o), 32'(h));
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic busy_bad;
        logic timeout;

        checks = 0;
        errors = 0;

        //            area    perim  found  w      h      latency
        vecs[0]  = '{8'd12,  6'd14, 1'b1, 4'd3,  4'd4,  4};
        vecs[1]  = '{8'd12,  6'd13, 1'b0, 4'd0,  4'd0,  1};
        vecs[2]  = '{8'd225, 6'd60, 1'b1, 4'd15, 4'd15, 16};
        vecs[3]  = '{8'd7,   6'd20, 1'b0, 4'd0,  4'd0,  6};
        vecs[4]  = '{8'd0,   6'd10, 1'b1, 4'd0,  4'd5,  1};
        vecs[5]  = '{8'd6,   6'd10, 1'b1, 4'd2,  4'd3,  3};
        vecs[6]  = '{8'd0,   6'd0,  1'b1, 4'd0,  4'd0,  1};
        vecs[7]  = '{8'd5,   6'd0,  1'b0, 4'd0,  4'd0,  1};
        vecs[8]  = '{8'd0,   6'd62, 1'b0, 4'd0,  4'd0,  16};
        vecs[9]  = '{8'd240, 6'd62, 1'b0, 4'd0,  4'd0,  16};
        vecs[10] = '{8'd64,  6'd32, 1'b1, 4'd8,  4'd8,  9};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.area_i    = '0;
        bus.perim_i   = '0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_found", 32'(bus.found_o), 32'd0);
        check("rst_w", 32'(bus.w_o), 32'd0);
        check("rst_h", 32'(bus.h_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].area, vecs[i].perim, lat, busy_bad, timeout);
            check($sformatf("v%0d_timeout", i), 32'(timeout), 32'd0);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_in_ready_busy", i), 32'(busy_bad), 32'd0);
            check($sformatf("v%0d_found", i), 32'(bus.found_o), 32'(vecs[i].found));
            check($sformatf("v%0d_w", i), 32'(bus.w_o), 32'(vecs[i].w));
            check($sformatf("v%0d_h", i), 32'(bus.h_o), 32'(vecs[i].h));
            accept(vecs[i].found, vecs[i].w, vecs[i].h);
        end

        // Result held stable while the consumer stalls.
        send(8'd16, 6'd16, lat, busy_bad, timeout);
        check("hold_timeout", 32'(timeout), 32'd0);
        check("hold_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
            check($sformatf("hold%0d_found", i), 32'(bus.found_o), 32'd1);
            check($sformatf("hold%0d_w", i), 32'(bus.w_o), 32'd4);
            check($sformatf("hold%0d_h", i), 32'(bus.h_o), 32'd4);
        end
        accept(1'b1, 4'd4, 4'd4);

        // Reset in the middle of a search aborts it.
        @(negedge clk);
        bus.area_i   = 8'd225;
        bus.perim_i  = 6'd60;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid_search_in_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_found", 32'(bus.found_o), 32'd0);
        check("abort_w", 32'(bus.w_o), 32'd0);
        check("abort_h", 32'(bus.h_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'd6, 6'd10, lat, busy_bad, timeout);
        check("post_rst_timeout", 32'(timeout), 32'd0);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_found", 32'(bus.found_o), 32'd1);
        check("post_rst_w", 32'(bus.w_o), 32'd2);
        check("post_rst_h", 32'(bus.h_o), 32'd3);
        accept(1'b1, 4'd2, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
